// File: rtl/pokey_bus_bridge.sv
// Cartridge-bus front end for the POKEY core: captures CPU writes to the POKEY window,
// queues them, replays them as register-write strobes, and generates the 1.79 MHz enable tick.
package pokey_bus_bridge_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } drain_state_t;
endpackage

module pokey_bus_bridge
    import pokey_bus_bridge_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0450,
    parameter int unsigned TICK_NUM   = 1789773,
    parameter int unsigned TICK_DEN   = 27000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bus_phi2,
    input  logic                          bus_rw,
    input  logic [15:0]                   bus_addr,
    input  logic [7:0]                    bus_data,
    output logic                          enable_179mhz,
    output logic [3:0]                    pokey_addr,
    output logic [7:0]                    pokey_din,
    output logic                          pokey_we,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [26:0] NUM27 = 27'(TICK_NUM);
    localparam logic [26:0] DEN27 = 27'(TICK_DEN);

    logic          s1_r, s2_r, s3_r;
    logic          fall_s;
    logic [15:0]   hold_addr_r;
    logic [7:0]    hold_data_r;
    logic          hold_rw_r;
    logic          push_r;
    logic [3:0]    push_addr_r;
    logic [7:0]    push_data_r;

    logic [11:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s, push_ok_s, pop_s;

    drain_state_t  state_r, state_nxt_s;

    logic [25:0]   acc_r;
    logic [26:0]   acc_sum_s;

    assign fall_s     = ~s2_r & s3_r;
    assign full_s     = (count_r == CW'(FIFO_DEPTH));
    assign push_ok_s  = push_r & (~full_s | pop_s);
    assign fifo_level = count_r;
    assign acc_sum_s  = {1'b0, acc_r} + NUM27;

    // PHI2 synchroniser, bus holding registers and registered capture decision
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r        <= 1'b0;
            s2_r        <= 1'b0;
            s3_r        <= 1'b0;
            hold_addr_r <= 16'h0000;
            hold_data_r <= 8'h00;
            hold_rw_r   <= 1'b0;
            push_r      <= 1'b0;
            push_addr_r <= 4'h0;
            push_data_r <= 8'h00;
        end else begin
            s1_r <= bus_phi2;
            s2_r <= s1_r;
            s3_r <= s2_r;
            // Pins are only trusted while PHI2 is high; the last high-phase value is kept
            if (s1_r) begin
                hold_addr_r <= bus_addr;
                hold_data_r <= bus_data;
                hold_rw_r   <= bus_rw;
            end
            push_r      <= fall_s & ~hold_rw_r & (hold_addr_r[15:4] == BASE_ADDR[15:4]);
            push_addr_r <= hold_addr_r[3:0];
            push_data_r <= hold_data_r;
        end
    end

    // Write queue storage, pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_r[i] <= 12'h000;
            end
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            overflow <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= {push_addr_r, push_data_r};
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_r & full_s & ~pop_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // Drain FSM next-state: pop from IDLE, then one dead cycle in GAP
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CW'(0)) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Drain FSM state register and registered POKEY write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pokey_we   <= 1'b0;
            pokey_addr <= 4'h0;
            pokey_din  <= 8'h00;
        end else begin
            state_r  <= state_nxt_s;
            pokey_we <= pop_s;
            if (pop_s) begin
                {pokey_addr, pokey_din} <= mem_r[rd_ptr_r];
            end
        end
    end

    // Fractional-rate tick: accumulator wraps by TICK_DEN and flags each wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r         <= 26'd0;
            enable_179mhz <= 1'b0;
        end else if (acc_sum_s >= DEN27) begin
            acc_r         <= 26'(acc_sum_s - DEN27);
            enable_179mhz <= 1'b1;
        end else begin
            acc_r         <= acc_sum_s[25:0];
            enable_179mhz <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pokey_bus_bridge.sv
// Directed self-checking bench for pokey_bus_bridge: reset, tick cadence, capture latency,
// address filtering, queue overflow and mid-queue reset.
module tb_pokey_bus_bridge;
    import pokey_bus_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_phi2;
    logic        bus_rw;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        enable_179mhz;
    logic [3:0]  pokey_addr;
    logic [7:0]  pokey_din;
    logic        pokey_we;
    logic [2:0]  fifo_level;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;
    int lvl_max  = 0;
    int first, ticks, last, gap_bad, idx;

    always #5 clk = ~clk;

    pokey_bus_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .bus_phi2      (bus_phi2),
        .bus_rw        (bus_rw),
        .bus_addr      (bus_addr),
        .bus_data      (bus_data),
        .enable_179mhz (enable_179mhz),
        .pokey_addr    (pokey_addr),
        .pokey_din     (pokey_din),
        .pokey_we      (pokey_we),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pokey_we === 1'b1) we_cnt++;
        if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                             input int h, input int l);
        bus_addr = a;
        bus_data = d;
        bus_rw   = rw;
        bus_phi2 = 1'b1;
        repeat (h) step();
        bus_phi2 = 1'b0;
        repeat (l) step();
    endtask

    initial begin
        reset    = 1'b1;
        bus_phi2 = 1'b0;
        bus_rw   = 1'b1;
        bus_addr = 16'h0000;
        bus_data = 8'h00;
        step();
        step();
        check_value("rst_tick", 32'(enable_179mhz), 32'd0);
        check_value("rst_we", 32'(pokey_we), 32'd0);
        check_value("rst_addr", 32'(pokey_addr), 32'd0);
        check_value("rst_din", 32'(pokey_din), 32'd0);
        check_value("rst_level", 32'(fifo_level), 32'd0);
        check_value("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Tick cadence over 1000 accumulations: floor(1000*1789773/27000000) = 66
        first = 0; ticks = 0; last = 0; gap_bad = 0;
        for (int n = 1; n <= 1000; n++) begin
            step();
            if (enable_179mhz === 1'b1) begin
                ticks++;
                if (first == 0) first = n;
                else if ((n - last) != 15 && (n - last) != 16) gap_bad++;
                last = n;
            end
        end
        check_value("first_tick", 32'(first), 32'd16);
        check_value("tick_count", 32'(ticks), 32'd66);
        check_value("tick_gaps", 32'(gap_bad), 32'd0);

        // Basic write: strobe high after edge k+4
        we_cnt   = 0;
        bus_addr = 16'h0452;
        bus_data = 8'hA5;
        bus_rw   = 1'b0;
        bus_phi2 = 1'b1;
        repeat (8) step();
        bus_phi2 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) check_value("we_before", 32'(pokey_we), 32'd0);
            if (i == 5) begin
                check_value("we_latency", 32'(pokey_we), 32'd1);
                check_value("basic_addr", 32'(pokey_addr), 32'd2);
                check_value("basic_din", 32'(pokey_din), 32'hA5);
            end
        end
        check_value("basic_pulses", 32'(we_cnt), 32'd1);
        check_value("basic_level", 32'(fifo_level), 32'd0);

        // Filtering: out-of-window write and in-window read
        we_cnt  = 0;
        lvl_max = 0;
        bus_cycle(16'h0460, 8'h77, 1'b0, 8, 8);
        bus_cycle(16'h0453, 8'h88, 1'b1, 8, 8);
        check_value("filter_we", 32'(we_cnt), 32'd0);
        check_value("filter_level", 32'(lvl_max), 32'd0);

        // Overflow: drain held off, five pushes into a four-entry queue
        force dut.state_r = ST_GAP;
        for (int i = 0; i < 5; i++) begin
            bus_cycle(16'h0450 + 16'(i), 8'h10 + 8'(i), 1'b0, 3, 3);
        end
        repeat (4) step();
        check_value("ovf_level", 32'(fifo_level), 32'd4);
        check_value("ovf_flag", 32'(overflow), 32'd1);
        release dut.state_r;
        idx = 0; last = 0; gap_bad = 0;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (pokey_we === 1'b1) begin
                check_value("drain_addr", 32'(pokey_addr), 32'(idx));
                check_value("drain_din", 32'(pokey_din), 32'h10 + 32'(idx));
                if (idx > 0 && (n - last) != 2) gap_bad++;
                last = n;
                idx++;
            end
        end
        check_value("drain_count", 32'(idx), 32'd4);
        check_value("drain_spacing", 32'(gap_bad), 32'd0);
        check_value("drain_level", 32'(fifo_level), 32'd0);
        check_value("ovf_sticky", 32'(overflow), 32'd1);

        // Reset with three writes queued
        force dut.state_r = ST_GAP;
        for (int i = 0; i < 3; i++) begin
            bus_cycle(16'h0458 + 16'(i), 8'h20 + 8'(i), 1'b0, 3, 3);
        end
        repeat (4) step();
        check_value("mid_level", 32'(fifo_level), 32'd3);
        reset = 1'b1;
        release dut.state_r;
        we_cnt = 0;
        step();
        check_value("mid_rst_level", 32'(fifo_level), 32'd0);
        check_value("mid_rst_ovf", 32'(overflow), 32'd0);
        check_value("mid_rst_we", 32'(pokey_we), 32'd0);
        check_value("mid_rst_tick", 32'(enable_179mhz), 32'd0);
        reset = 1'b0;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (enable_179mhz === 1'b1 && first == 0) first = n;
        end
        check_value("mid_first_tick", 32'(first), 32'd16);
        check_value("mid_no_we", 32'(we_cnt), 32'd0);
        check_value("mid_level_after", 32'(fifo_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
